// File: rtl/modrm_decoder.sv
// ModR/M byte decoder: fetches the ModR/M byte plus 0/1/2 displacement bytes over a
// valid/ready byte stream and holds the decoded operands until acknowledged.
module modrm_decoder (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        result_valid,
    input  logic        result_ack,
    output logic [1:0]  mod,
    output logic [2:0]  reg_field,
    output logic [2:0]  rm,
    output logic [15:0] displacement,
    output logic [1:0]  byte_count,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MODRM   = 3'd1,
        DISP_LO = 3'd2,
        DISP_HI = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t state, state_next;
    logic   disp_wide;   // displacement of the current decode is 16 bits
    logic   xfer;
    logic   modrm_no_disp;
    logic   modrm_wide;

    // Displacement requirement of the byte currently on the stream (valid in MODRM).
    assign modrm_no_disp = (byte_in[7:6] == 2'b11) ||
                           (byte_in[7:6] == 2'b00 && byte_in[2:0] != 3'b110);
    assign modrm_wide    = (byte_in[7:6] == 2'b10) ||
                           (byte_in[7:6] == 2'b00 && byte_in[2:0] == 3'b110);

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        if (!abort)
            byte_ready = (state == MODRM) || (state == DISP_LO) || (state == DISP_HI);
        xfer = byte_valid && byte_ready;

        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_next = MODRM;
                MODRM:   if (xfer) state_next = modrm_no_disp ? DONE : DISP_LO;
                DISP_LO: if (xfer) state_next = disp_wide ? DISP_HI : DONE;
                DISP_HI: if (xfer) state_next = DONE;
                DONE:    if (result_ack) state_next = start ? MODRM : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            mod          <= 2'd0;
            reg_field    <= 3'd0;
            rm           <= 3'd0;
            displacement <= 16'd0;
            byte_count   <= 2'd0;
            disp_wide    <= 1'b0;
        end else begin
            state        <= state_next;
            result_valid <= (state_next == DONE);
            busy         <= (state_next != IDLE);

            if (state_next == MODRM && (state == IDLE || state == DONE))
                displacement <= 16'd0;

            if (xfer) begin
                case (state)
                    MODRM: begin
                        mod        <= byte_in[7:6];
                        reg_field  <= byte_in[5:3];
                        rm         <= byte_in[2:0];
                        byte_count <= 2'd1;
                        disp_wide  <= modrm_wide;
                    end
                    DISP_LO: begin
                        byte_count <= 2'd2;
                        if (disp_wide)
                            displacement[7:0] <= byte_in;
                        else
                            displacement <= {{8{byte_in[7]}}, byte_in};
                    end
                    DISP_HI: begin
                        byte_count         <= 2'd3;
                        displacement[15:8] <= byte_in;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_modrm_decoder.sv
// Directed self-checking bench for modrm_decoder: register form, disp8/disp16,
// stalls, back-to-back decode, abort and asynchronous reset.
module tb_modrm_decoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, abort, byte_valid, result_ack;
    logic [7:0]  byte_in;
    logic        byte_ready, result_valid, busy;
    logic [1:0]  mod, byte_count;
    logic [2:0]  reg_field, rm;
    logic [15:0] displacement;

    int checks   = 0;
    int failures = 0;

    modrm_decoder dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .mod          (mod),
        .reg_field    (reg_field),
        .rm           (rm),
        .displacement (displacement),
        .byte_count   (byte_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_decode();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_in    = b;
        tick();
        byte_valid = 1'b0;
        byte_in    = 8'h00;
    endtask

    task automatic acknowledge();
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rv"},   {15'd0, result_valid}, 16'd0);
        check({tag, "_busy"}, {15'd0, busy},         16'd0);
        check({tag, "_rdy"},  {15'd0, byte_ready},   16'd0);
        check({tag, "_mod"},  {14'd0, mod},          16'd0);
        check({tag, "_reg"},  {13'd0, reg_field},    16'd0);
        check({tag, "_rm"},   {13'd0, rm},           16'd0);
        check({tag, "_disp"}, displacement,          16'h0000);
        check({tag, "_cnt"},  {14'd0, byte_count},   16'd0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; byte_valid = 1'b0;
        result_ack = 1'b0; byte_in = 8'h00;
        #22;
        check_reset_values("reset");
        tick();
        reset_n = 1'b1;
        tick();

        // Register form: 0xD8, result two cycles after start.
        begin_decode();
        check("reg_ready", {15'd0, byte_ready}, 16'd1);
        check("reg_busy",  {15'd0, busy},       16'd1);
        send_byte(8'hD8);
        check("reg_rv",   {15'd0, result_valid}, 16'd1);
        check("reg_mod",  {14'd0, mod},          16'd3);
        check("reg_reg",  {13'd0, reg_field},    16'd3);
        check("reg_rm",   {13'd0, rm},           16'd0);
        check("reg_disp", displacement,          16'h0000);
        check("reg_cnt",  {14'd0, byte_count},   16'd1);
        check("reg_rdy0", {15'd0, byte_ready},   16'd0);
        tick();
        check("reg_hold", {15'd0, result_valid}, 16'd1);
        acknowledge();
        check("reg_ack_rv",   {15'd0, result_valid}, 16'd0);
        check("reg_ack_busy", {15'd0, busy},         16'd0);
        check("idle_hold_mod", {14'd0, mod},         16'd3);

        // disp8, negative then positive.
        begin_decode();
        send_byte(8'h46);
        check("d8_mid_rv",  {15'd0, result_valid}, 16'd0);
        check("d8_mid_rdy", {15'd0, byte_ready},   16'd1);
        send_byte(8'hFE);
        check("d8n_rv",   {15'd0, result_valid}, 16'd1);
        check("d8n_mod",  {14'd0, mod},          16'd1);
        check("d8n_rm",   {13'd0, rm},           16'd6);
        check("d8n_disp", displacement,          16'hFFFE);
        check("d8n_cnt",  {14'd0, byte_count},   16'd2);
        acknowledge();
        begin_decode();
        check("start_clears_disp", displacement, 16'h0000);
        send_byte(8'h46);
        send_byte(8'h7F);
        check("d8p_rv",   {15'd0, result_valid}, 16'd1);
        check("d8p_disp", displacement,          16'h007F);
        acknowledge();

        // Direct address with 3-cycle stalls between bytes.
        begin_decode();
        send_byte(8'h06);
        repeat (3) tick();
        check("dir_stall1_rdy", {15'd0, byte_ready},   16'd1);
        check("dir_stall1_cnt", {14'd0, byte_count},   16'd1);
        check("dir_stall1_rv",  {15'd0, result_valid}, 16'd0);
        send_byte(8'h34);
        repeat (3) tick();
        check("dir_stall2_rdy", {15'd0, byte_ready},   16'd1);
        check("dir_stall2_cnt", {14'd0, byte_count},   16'd2);
        check("dir_stall2_rv",  {15'd0, result_valid}, 16'd0);
        send_byte(8'h12);
        check("dir_rv",   {15'd0, result_valid}, 16'd1);
        check("dir_mod",  {14'd0, mod},          16'd0);
        check("dir_rm",   {13'd0, rm},           16'd6);
        check("dir_disp", displacement,          16'h1234);
        check("dir_cnt",  {14'd0, byte_count},   16'd3);
        acknowledge();

        // disp16 followed by a back-to-back register-form decode.
        begin_decode();
        send_byte(8'h87);
        send_byte(8'hCD);
        check("d16_mid_rv", {15'd0, result_valid}, 16'd0);
        send_byte(8'hAB);
        check("d16_rv",   {15'd0, result_valid}, 16'd1);
        check("d16_mod",  {14'd0, mod},          16'd2);
        check("d16_rm",   {13'd0, rm},           16'd7);
        check("d16_disp", displacement,          16'hABCD);
        result_ack = 1'b1;
        start      = 1'b1;
        tick();
        result_ack = 1'b0;
        start      = 1'b0;
        check("b2b_rv",   {15'd0, result_valid}, 16'd0);
        check("b2b_busy", {15'd0, busy},         16'd1);
        check("b2b_rdy",  {15'd0, byte_ready},   16'd1);
        check("b2b_disp", displacement,          16'h0000);
        send_byte(8'hC0);
        check("b2b2_rv",   {15'd0, result_valid}, 16'd1);
        check("b2b2_mod",  {14'd0, mod},          16'd3);
        check("b2b2_disp", displacement,          16'h0000);
        check("b2b2_cnt",  {14'd0, byte_count},   16'd1);
        acknowledge();

        // Abort in DISP_HI; the byte offered alongside abort is dropped.
        begin_decode();
        send_byte(8'h80);
        send_byte(8'h11);
        check("ab_pre_rdy", {15'd0, byte_ready}, 16'd1);
        abort      = 1'b1;
        byte_valid = 1'b1;
        byte_in    = 8'h99;
        #1;
        check("ab_rdy_low", {15'd0, byte_ready}, 16'd0);
        tick();
        abort      = 1'b0;
        byte_valid = 1'b0;
        check("ab_busy", {15'd0, busy},         16'd0);
        check("ab_rv",   {15'd0, result_valid}, 16'd0);
        check("ab_rdy",  {15'd0, byte_ready},   16'd0);
        check("ab_disp", displacement,          16'h0011);
        check("ab_cnt",  {14'd0, byte_count},   16'd2);
        repeat (3) tick();
        check("ab_rv_later", {15'd0, result_valid}, 16'd0);

        // Asynchronous reset in DISP_LO, then a clean decode.
        begin_decode();
        send_byte(8'h86);
        check("rst_pre_busy", {15'd0, busy}, 16'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("async");
        tick();
        reset_n = 1'b1;
        tick();
        begin_decode();
        send_byte(8'hD8);
        check("post_rst_rv",   {15'd0, result_valid}, 16'd1);
        check("post_rst_mod",  {14'd0, mod},          16'd3);
        check("post_rst_reg",  {13'd0, reg_field},    16'd3);
        check("post_rst_disp", displacement,          16'h0000);
        check("post_rst_cnt",  {14'd0, byte_count},   16'd1);
        acknowledge();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
